// File: rtl/uart_step_controller.sv
// rtl/uart_step_controller.sv - UART step/debug controller between a byte UART and a single-step CPU core
//
// Ports:
//   clk, reset            single clock, asynchronous active-low reset
//   rx_data, rx_valid     received host byte and its one-cycle strobe
//   tx_data, tx_valid,    byte to the host; taken when tx_valid & tx_ready
//   tx_ready
//   pc                    current CPU program counter
//   cpu_reset, cpu_run    one-cycle CPU reset and single-step pulses
//   instr                 instruction register driven into the core
//   mem_we, mem_re,       CPU store/load request and its attributes,
//   mem_addr, mem_wdata,  sampled only while evaluating a fresh instruction
//   mem_wstrb, mem_size
//   mem_rdata             load data supplied by the host
//   state_dbg             current state encoding
//   err                   sticky receive-timeout flag
module uart_step_controller #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [XLEN-1:0]   pc,
    output logic              cpu_reset,
    output logic              cpu_run,
    output logic [31:0]       instr,
    input  logic              mem_we,
    input  logic              mem_re,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN/8-1:0] mem_wstrb,
    input  logic [2:0]        mem_size,
    output logic [XLEN-1:0]   mem_rdata,
    output logic [3:0]        state_dbg,
    output logic              err
);

    localparam int DBYTES = XLEN / 8;
    localparam int ABYTES = ADDR_W / 8;

    typedef enum logic [3:0] {
        S_BOOT       = 4'd0,
        S_CMD        = 4'd1,
        S_SEND_ACK   = 4'd2,
        S_SEND_NAK   = 4'd3,
        S_SEND_PC    = 4'd4,
        S_RX_COUNT   = 4'd5,
        S_RX_INSTR   = 4'd6,
        S_EVAL       = 4'd7,
        S_SEND_TAG   = 4'd8,
        S_SEND_ADDR  = 4'd9,
        S_SEND_ATTR  = 4'd10,
        S_SEND_WDATA = 4'd11,
        S_RX_RDATA   = 4'd12,
        S_STEP       = 4'd13
    } state_t;

    state_t            state;
    logic [7:0]        cnt;        // shared byte counter for multi-byte fields
    logic [8:0]        remaining;  // steps left in the current burst (256 max)
    logic [ADDR_W-1:0] addr_sh;
    logic [XLEN-1:0]   data_sh;    // pc or store data, shifted out LSB-first
    logic [XLEN-9:0]   rx_sh;      // earlier bytes of the field being received
    logic [7:0]        attr;
    logic              is_store;
    logic [31:0]       idle;
    logic              timeout;

    assign state_dbg = state;
    assign timeout   = (TIMEOUT_CYC != 0) && (idle == 32'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_BOOT;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            cpu_reset <= 1'b0;
            cpu_run   <= 1'b0;
            instr     <= 32'h0;
            mem_rdata <= '0;
            err       <= 1'b0;
            cnt       <= 8'd0;
            remaining <= 9'd0;
            addr_sh   <= '0;
            data_sh   <= '0;
            rx_sh     <= '0;
            attr      <= 8'h00;
            is_store  <= 1'b0;
            idle      <= 32'd0;
        end else begin
            cpu_reset <= 1'b0;
            cpu_run   <= 1'b0;
            case (state)
                S_BOOT: begin
                    cpu_reset <= 1'b1;
                    instr     <= 32'h0;
                    mem_rdata <= '0;
                    err       <= 1'b0;
                    remaining <= 9'd0;
                    tx_valid  <= 1'b0;
                    state     <= S_SEND_ACK;
                end
                S_SEND_ACK, S_SEND_NAK: begin
                    // STEP preloads the ACK so it leaves one cycle after cpu_run
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= (state == S_SEND_ACK) ? 8'h01 : 8'hEE;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (rx_valid) begin
                        cnt  <= 8'd0;
                        idle <= 32'd0;
                        case (rx_data)
                            8'h01: state <= S_BOOT;
                            8'h02: begin
                                data_sh <= pc;
                                state   <= S_SEND_PC;
                            end
                            8'h03: begin
                                remaining <= 9'd1;
                                state     <= S_RX_INSTR;
                            end
                            8'h04:   state <= S_RX_COUNT;
                            default: state <= S_SEND_NAK;
                        endcase
                    end
                end
                S_SEND_PC, S_SEND_WDATA: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= data_sh[7:0];
                    end else if (tx_ready) begin
                        if (cnt == 8'(DBYTES - 1)) begin
                            tx_valid <= 1'b0;
                            if (state == S_SEND_PC) begin
                                state <= S_SEND_ACK;
                            end else begin
                                cpu_run <= 1'b1;
                                state   <= S_STEP;
                            end
                        end else begin
                            // next byte goes out back-to-back with the accepted one
                            cnt     <= cnt + 8'd1;
                            tx_data <= data_sh[15:8];
                            data_sh <= data_sh >> 8;
                        end
                    end
                end
                S_RX_COUNT: begin
                    if (rx_valid) begin
                        remaining <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        idle      <= 32'd0;
                        cnt       <= 8'd0;
                        state     <= S_RX_INSTR;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= S_SEND_NAK;
                    end else begin
                        idle <= idle + 32'd1;
                    end
                end
                S_RX_INSTR: begin
                    if (rx_valid) begin
                        idle  <= 32'd0;
                        rx_sh <= {rx_data, rx_sh[XLEN-9:8]};
                        if (cnt == 8'd3) begin
                            instr <= {rx_data, rx_sh[XLEN-9:XLEN-32]};
                            state <= S_EVAL;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= S_SEND_NAK;
                    end else begin
                        idle <= idle + 32'd1;
                    end
                end
                S_EVAL: begin
                    addr_sh <= mem_addr;
                    data_sh <= mem_wdata;
                    cnt     <= 8'd0;
                    if (mem_we) begin
                        is_store <= 1'b1;
                        attr     <= 8'(mem_wstrb);
                        state    <= S_SEND_TAG;
                    end else if (mem_re) begin
                        is_store <= 1'b0;
                        attr     <= {5'b0, mem_size};
                        state    <= S_SEND_TAG;
                    end else begin
                        cpu_run <= 1'b1;
                        state   <= S_STEP;
                    end
                end
                S_SEND_TAG: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= is_store ? 8'h30 : 8'h20;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_SEND_ADDR;
                    end
                end
                S_SEND_ADDR: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= addr_sh[7:0];
                    end else if (tx_ready) begin
                        if (cnt == 8'(ABYTES - 1)) begin
                            tx_valid <= 1'b0;
                            state    <= S_SEND_ATTR;
                        end else begin
                            cnt     <= cnt + 8'd1;
                            tx_data <= addr_sh[15:8];
                            addr_sh <= addr_sh >> 8;
                        end
                    end
                end
                S_SEND_ATTR: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= attr;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        cnt      <= 8'd0;
                        idle     <= 32'd0;
                        state    <= is_store ? S_SEND_WDATA : S_RX_RDATA;
                    end
                end
                S_RX_RDATA: begin
                    if (rx_valid) begin
                        idle  <= 32'd0;
                        rx_sh <= {rx_data, rx_sh[XLEN-9:8]};
                        if (cnt == 8'(DBYTES - 1)) begin
                            mem_rdata <= {rx_data, rx_sh};
                            cpu_run   <= 1'b1;
                            state     <= S_STEP;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= S_SEND_NAK;
                    end else begin
                        idle <= idle + 32'd1;
                    end
                end
                S_STEP: begin
                    // cpu_run was raised on entry, so this is the step cycle
                    remaining <= remaining - 9'd1;
                    if (remaining == 9'd1) begin
                        tx_valid <= 1'b1;
                        tx_data  <= 8'h01;
                        state    <= S_SEND_ACK;
                    end else begin
                        cnt   <= 8'd0;
                        idle  <= 32'd0;
                        state <= S_RX_INSTR;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_step_controller.sv
// tb/tb_uart_step_controller.sv - directed self-checking bench for uart_step_controller
module tb_uart_step_controller;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] pc;
    logic        cpu_reset;
    logic        cpu_run;
    logic [31:0] instr;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [2:0]  mem_size;
    logic [31:0] mem_rdata;
    logic [3:0]  state_dbg;
    logic        err;

    int          total = 0;
    int          bad = 0;
    byte_q_t     tx_q;
    int          run_cnt = 0;
    int          rst_cnt = 0;
    logic [31:0] rdata_at_run = 32'h0;
    int          qsize_at_run = 0;
    int          stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    int          ready_mode = 0;

    uart_step_controller #(
        .XLEN(32),
        .ADDR_W(32),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .pc(pc),
        .cpu_reset(cpu_reset),
        .cpu_run(cpu_run),
        .instr(instr),
        .mem_we(mem_we),
        .mem_re(mem_re),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_size(mem_size),
        .mem_rdata(mem_rdata),
        .state_dbg(state_dbg),
        .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (cpu_run) begin
            run_cnt      = run_cnt + 1;
            rdata_at_run = mem_rdata;
            qsize_at_run = tx_q.size();
        end
        if (cpu_reset) rst_cnt = rst_cnt + 1;
        if (prev_stall && (!tx_valid || tx_data != prev_data)) stall_err = stall_err + 1;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        sync();
        rx_valid = 1'b0;
    endtask

    task automatic wait_q(input int n, input int lim);
        int k;
        k = 0;
        while (tx_q.size() < n && k < lim) begin
            sync();
            k++;
        end
    endtask

    task automatic check_seq(input string tag, input byte_q_t exp);
        check({tag, "_len"}, 64'(tx_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < tx_q.size()) check($sformatf("%s_b%0d", tag, i), 64'(tx_q[i]), 64'(exp[i]));
        end
    endtask

    task automatic clear_mon();
        tx_q.delete();
        run_cnt = 0;
        rst_cnt = 0;
    endtask

    initial begin
        byte_q_t exp;
        int      cyc;

        reset     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        pc        = 32'h0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        mem_size  = 3'b000;

        // reset state
        repeat (3) sync();
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd0);
        check("rst_cpu_run", 64'(cpu_run), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_rdata", 64'(mem_rdata), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);

        // reset release: cpu_reset pulse, then ACK one cycle later
        clear_mon();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("boot_cpu_reset", 64'(cpu_reset), 64'd1);
        check("boot_tx_idle", 64'(tx_valid), 64'd0);
        @(negedge clk);
        check("boot_ack_valid", 64'(tx_valid), 64'd1);
        check("boot_ack_data", 64'(tx_data), 64'h01);
        check("boot_reset_low", 64'(cpu_reset), 64'd0);
        sync();
        wait_q(1, 50);
        exp = '{8'h01};
        check_seq("boot_tx", exp);
        check("boot_rst_cnt", 64'(rst_cnt), 64'd1);

        // GET_PC
        clear_mon();
        pc = 32'h0000_1234;
        send_byte(8'h02);
        wait_q(5, 100);
        exp = '{8'h34, 8'h12, 8'h00, 8'h00, 8'h01};
        check_seq("getpc", exp);

        // non-memory step with cycle timing
        clear_mon();
        repeat (2) sync();
        send_byte(8'h03);
        send_byte(8'h93);
        send_byte(8'h00);
        send_byte(8'h50);
        send_byte(8'h00);
        @(negedge clk);
        check("step_eval_state", 64'(state_dbg), 64'd7);
        check("step_instr", 64'(instr), 64'h0050_0093);
        @(negedge clk);
        check("step_cpu_run", 64'(cpu_run), 64'd1);
        @(negedge clk);
        check("step_ack_valid", 64'(tx_valid), 64'd1);
        check("step_ack_data", 64'(tx_data), 64'h01);
        sync();
        wait_q(1, 50);
        repeat (5) sync();
        exp = '{8'h01};
        check_seq("step_tx", exp);
        check("step_run_cnt", 64'(run_cnt), 64'd1);

        // load step
        clear_mon();
        mem_re   = 1'b1;
        mem_addr = 32'h8000_0010;
        mem_size = 3'b010;
        send_byte(8'h03);
        send_byte(8'h03);
        send_byte(8'hA0);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_q(6, 100);
        mem_re   = 1'b0;
        mem_addr = 32'h0;
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        wait_q(7, 100);
        exp = '{8'h20, 8'h10, 8'h00, 8'h00, 8'h80, 8'h02, 8'h01};
        check_seq("load_tx", exp);
        check("load_rdata_at_run", 64'(rdata_at_run), 64'hDEAD_BEEF);
        check("load_run_cnt", 64'(run_cnt), 64'd1);
        check("load_rdata_hold", 64'(mem_rdata), 64'hDEAD_BEEF);

        // store step with random tx_ready stalls; store wins over load
        clear_mon();
        mem_we     = 1'b1;
        mem_re     = 1'b1;
        mem_addr   = 32'h0000_0100;
        mem_wstrb  = 4'b0011;
        mem_wdata  = 32'h0000_ABCD;
        ready_mode = 1;
        send_byte(8'h03);
        send_byte(8'h23);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h00);
        sync();
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = 32'hFFFF_FFFF;
        wait_q(11, 400);
        ready_mode = 0;
        repeat (3) sync();
        exp = '{8'h30, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'hCD, 8'hAB, 8'h00, 8'h00, 8'h01};
        check_seq("store_tx", exp);
        check("store_run_cnt", 64'(run_cnt), 64'd1);
        check("store_run_order", 64'(qsize_at_run), 64'd10);
        check("store_tx_stable", 64'(stall_err), 64'd0);

        // burst of 3 steps, single ACK
        clear_mon();
        send_byte(8'h04);
        send_byte(8'h03);
        for (int w = 0; w < 3; w++) begin
            send_byte(8'h13);
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'h00);
            repeat (4) sync();
        end
        wait_q(1, 100);
        repeat (20) sync();
        exp = '{8'h01};
        check_seq("burst_tx", exp);
        check("burst_run_cnt", 64'(run_cnt), 64'd3);

        // unknown command
        clear_mon();
        send_byte(8'h7F);
        wait_q(1, 50);
        repeat (3) sync();
        exp = '{8'hEE};
        check_seq("nak_tx", exp);
        check("nak_err", 64'(err), 64'd0);

        // receive timeout
        clear_mon();
        send_byte(8'h03);
        send_byte(8'h93);
        send_byte(8'h00);
        cyc = 0;
        while (tx_q.size() < 1 && cyc < 300) begin
            sync();
            cyc++;
        end
        check("to_latency_ok", 64'((cyc >= 98) && (cyc <= 106)), 64'd1);
        repeat (3) sync();
        exp = '{8'hEE};
        check_seq("to_tx", exp);
        check("to_err", 64'(err), 64'd1);
        check("to_run_cnt", 64'(run_cnt), 64'd0);
        check("to_instr_kept", 64'(instr), 64'h0000_0013);

        // RESET command clears err and instr
        clear_mon();
        send_byte(8'h01);
        wait_q(1, 50);
        repeat (3) sync();
        exp = '{8'h01};
        check_seq("rstcmd_tx", exp);
        check("rstcmd_err", 64'(err), 64'd0);
        check("rstcmd_instr", 64'(instr), 64'd0);
        check("rstcmd_rst_cnt", 64'(rst_cnt), 64'd1);

        // asynchronous reset in the middle of a stalled transfer
        clear_mon();
        ready_mode = 2;
        repeat (2) sync();
        send_byte(8'h02);
        repeat (4) sync();
        check("areset_pre_state", 64'(state_dbg), 64'd4);
        check("areset_pre_valid", 64'(tx_valid), 64'd1);
        check("areset_pre_data", 64'(tx_data), 64'h34);
        reset = 1'b0;
        #1;
        check("areset_tx_valid", 64'(tx_valid), 64'd0);
        check("areset_state", 64'(state_dbg), 64'd0);
        repeat (5) sync();
        ready_mode = 0;
        reset      = 1'b1;
        wait_q(1, 50);
        repeat (3) sync();
        exp = '{8'h01};
        check_seq("areset_tx", exp);
        check("areset_run_cnt", 64'(run_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
